// File: rtl/mux_2_1_rr_arb.sv
// Two-input round-robin arbiter feeding a registered 2:1 mux output stage.
// Per-source saturating transfer counters track accepted words for debug.
module mux_2_1_rr_arb #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       in_valid,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    output logic [1:0]       in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sel,
    input  logic             out_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_sel_q,   out_sel_d;
    logic             last_q,      last_d;
    logic [CNT_W-1:0] cnt0_q,      cnt0_d;
    logic [CNT_W-1:0] cnt1_q,      cnt1_d;

    logic       load_s;
    logic [1:0] grant_s;
    logic [1:0] in_ready_s;
    logic       accept_s;
    logic       acc_idx_s;

    // Grant selection: a lone requester always wins; contention goes to !last.
    always_comb begin
        grant_s = 2'b00;
        case (in_valid)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11:   grant_s = last_q ? 2'b01 : 2'b10;
            default: grant_s = 2'b00;
        endcase
    end

    // Handshake: ready only while the output register can take a word.
    always_comb begin
        load_s     = !out_valid_q || out_ready;
        in_ready_s = 2'b00;
        if (rst) begin
            in_ready_s = 2'b00;
        end else if (load_s) begin
            in_ready_s = grant_s;
        end else begin
            in_ready_s = 2'b00;
        end
        accept_s  = |(in_valid & in_ready_s);
        acc_idx_s = in_ready_s[1];
    end

    // Next-state for the output stage, priority pointer and counters.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        last_d      = last_q;
        cnt0_d      = cnt0_q;
        cnt1_d      = cnt1_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_idx_s ? in_data1 : in_data0;
            out_sel_d   = acc_idx_s;
            last_d      = acc_idx_s;
            if (!acc_idx_s && (cnt0_q != CNT_MAX)) begin
                cnt0_d = cnt0_q + CNT_ONE;
            end else if (acc_idx_s && (cnt1_q != CNT_MAX)) begin
                cnt1_d = cnt1_q + CNT_ONE;
            end else begin
                cnt0_d = cnt0_q;
                cnt1_d = cnt1_q;
            end
        end else if (load_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State register; last resets to 1 so source 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= {WIDTH{1'b0}};
            out_sel_q   <= 1'b0;
            last_q      <= 1'b1;
            cnt0_q      <= {CNT_W{1'b0}};
            cnt1_q      <= {CNT_W{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            last_q      <= last_d;
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign cnt0      = cnt0_q;
    assign cnt1      = cnt1_q;

endmodule

// File: tb/tb_mux_2_1_rr_arb.sv
// Directed self-checking bench for mux_2_1_rr_arb (2-bit counters to reach saturation).
module tb_mux_2_1_rr_arb;

    localparam int WIDTH = 8;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic [1:0]       in_valid;
    logic [WIDTH-1:0] in_data0;
    logic [WIDTH-1:0] in_data1;
    logic [1:0]       in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_sel;
    logic             out_ready;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    int checks;
    int fails;

    mux_2_1_rr_arb #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready),
        .cnt0      (cnt0),
        .cnt1      (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 2'b00;
        out_ready = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 2'b11;
        in_data0  = 8'h11;
        in_data1  = 8'h22;
        out_ready = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (in_ready !== 2'b00) begin
                fails++;
                $display("FAIL reset_in_ready[%0d]: got %b expected 00", k, in_ready);
            end
            step();
        end
        rst      = 1'b0;
        in_valid = 2'b00;
        #1;
        checks++;
        if ({out_valid, out_data, out_sel, cnt0, cnt1} !== {1'b0, 8'h00, 1'b0, 2'd0, 2'd0}) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b d=%h s=%b c0=%0d c1=%0d expected all 0",
                     out_valid, out_data, out_sel, cnt0, cnt1);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL idle_valid: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_contended();
        logic [1:0]       exp_rdy [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic             exp_sel [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [WIDTH-1:0] exp_dat [4] = '{8'hA0, 8'hB1, 8'hA0, 8'hB1};
        in_valid  = 2'b11;
        in_data0  = 8'hA0;
        in_data1  = 8'hB1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (in_ready !== exp_rdy[k]) begin
                fails++;
                $display("FAIL contend_ready[%0d]: got %b expected %b", k, in_ready, exp_rdy[k]);
            end
            step();
            checks++;
            if ({out_valid, out_sel, out_data} !== {1'b1, exp_sel[k], exp_dat[k]}) begin
                fails++;
                $display("FAIL contend_out[%0d]: got v=%b s=%b d=%h expected v=1 s=%b d=%h",
                         k, out_valid, out_sel, out_data, exp_sel[k], exp_dat[k]);
            end
        end
        in_valid = 2'b00;
        checks++;
        if ({cnt0, cnt1} !== {2'd2, 2'd2}) begin
            fails++;
            $display("FAIL contend_cnt: got c0=%0d c1=%0d expected 2 2", cnt0, cnt1);
        end
        step();
    endtask

    task automatic test_single();
        do_reset();
        in_valid  = 2'b10;
        in_data1  = 8'h3C;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (in_ready !== 2'b10) begin
                fails++;
                $display("FAIL single_ready[%0d]: got %b expected 10", k, in_ready);
            end
            step();
            checks++;
            if ({out_valid, out_sel, out_data} !== {1'b1, 1'b1, 8'h3C}) begin
                fails++;
                $display("FAIL single_out[%0d]: got v=%b s=%b d=%h expected v=1 s=1 d=3c",
                         k, out_valid, out_sel, out_data);
            end
        end
        in_valid = 2'b00;
        checks++;
        if ({cnt0, cnt1} !== {2'd0, 2'd3}) begin
            fails++;
            $display("FAIL single_cnt: got c0=%0d c1=%0d expected 0 3", cnt0, cnt1);
        end
        step();
    endtask

    task automatic test_backpressure();
        in_valid  = 2'b01;
        in_data0  = 8'hA0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 2'b11;
        in_data0  = 8'h55;
        in_data1  = 8'h66;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (in_ready !== 2'b00) begin
                fails++;
                $display("FAIL bp_ready[%0d]: got %b expected 00", k, in_ready);
            end
            step();
            checks++;
            if ({out_valid, out_sel, out_data} !== {1'b1, 1'b0, 8'hA0}) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got v=%b s=%b d=%h expected v=1 s=0 d=a0",
                         k, out_valid, out_sel, out_data);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 2'b10) begin
            fails++;
            $display("FAIL bp_release_ready: got %b expected 10", in_ready);
        end
        step();
        in_valid = 2'b00;
        checks++;
        if ({out_valid, out_sel, out_data} !== {1'b1, 1'b1, 8'h66}) begin
            fails++;
            $display("FAIL bp_release_out: got v=%b s=%b d=%h expected v=1 s=1 d=66",
                     out_valid, out_sel, out_data);
        end
    endtask

    task automatic test_drain();
        in_valid  = 2'b00;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 2'b00) begin
            fails++;
            $display("FAIL drain_ready: got %b expected 00", in_ready);
        end
        step();
        checks++;
        if ({out_valid, out_sel, out_data} !== {1'b0, 1'b1, 8'h66}) begin
            fails++;
            $display("FAIL drain_out: got v=%b s=%b d=%h expected v=0 s=1 d=66",
                     out_valid, out_sel, out_data);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL drain_stay_empty: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_saturation_reset();
        logic [CNT_W-1:0] exp_c0 [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        in_valid  = 2'b01;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_data0 = 8'h10 + 8'(k);
            step();
            checks++;
            if ({cnt0, cnt1} !== {exp_c0[k], 2'd0}) begin
                fails++;
                $display("FAIL sat_cnt[%0d]: got c0=%0d c1=%0d expected %0d 0",
                         k, cnt0, cnt1, exp_c0[k]);
            end
        end
        out_ready = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL sat_full: got %b expected 1", out_valid);
        end
        rst      = 1'b1;
        in_valid = 2'b11;
        step();
        checks++;
        if ({out_valid, out_sel, out_data, cnt0, cnt1} !== {1'b0, 1'b0, 8'h00, 2'd0, 2'd0}) begin
            fails++;
            $display("FAIL midrst_out: got v=%b s=%b d=%h c0=%0d c1=%0d expected all 0",
                     out_valid, out_sel, out_data, cnt0, cnt1);
        end
        rst       = 1'b0;
        out_ready = 1'b1;
        in_data0  = 8'h77;
        in_data1  = 8'h88;
        #1;
        checks++;
        if (in_ready !== 2'b01) begin
            fails++;
            $display("FAIL midrst_grant: got %b expected 01", in_ready);
        end
        step();
        in_valid = 2'b00;
        checks++;
        if ({out_valid, out_sel, out_data, cnt0} !== {1'b1, 1'b0, 8'h77, 2'd1}) begin
            fails++;
            $display("FAIL midrst_first: got v=%b s=%b d=%h c0=%0d expected v=1 s=0 d=77 c0=1",
                     out_valid, out_sel, out_data, cnt0);
        end
    endtask

    initial begin
        checks    = 0;
        fails     = 0;
        rst       = 1'b1;
        in_valid  = 2'b00;
        in_data0  = 8'h00;
        in_data1  = 8'h00;
        out_ready = 1'b0;
        test_reset();
        test_contended();
        test_single();
        test_backpressure();
        test_drain();
        test_saturation_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
